// File: rtl/bm_cf_rom_arb.sv
// Two-requester arbiter for a shared coefficient ROM with burst-limited fairness
// and a two-stage response pipeline. Optional grant statistics: BM_CF_ARB_STATS_EN.
module bm_cf_rom_arb #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [6:0]  addr0,
  input  logic [6:0]  addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [6:0]  rom_addr,
  input  logic [32:0] rom_rdata,
  output logic        rvalid,
  output logic        rid,
  output logic [32:0] rdata
`ifdef BM_CF_ARB_STATS_EN
  ,
  output logic [15:0] gcnt0,
  output logic [15:0] gcnt1
`endif
);

  localparam int unsigned CW = $clog2(BURST_MAX) + 1;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 33;

  logic          owner, owner_d;
  logic [CW-1:0] bcnt, bcnt_d;
  logic          grant_v, grant_id;
  logic          s1_v, s1_id;

  // Arbitration state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b0;
      bcnt  <= '0;
    end else begin
      owner <= owner_d;
      bcnt  <= bcnt_d;
    end
  end

  // Grant decision and next arbitration state; bcnt saturates at BURST_MAX,
  // which is all the contention rule needs to distinguish.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    owner_d  = owner;
    bcnt_d   = bcnt;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rom_addr = addr0;

    if (req0 && req1) begin
      grant_v  = 1'b1;
      grant_id = (bcnt < CW'(BURST_MAX)) ? owner : ~owner;
    end else if (req0) begin
      grant_v  = 1'b1;
      grant_id = 1'b0;
    end else if (req1) begin
      grant_v  = 1'b1;
      grant_id = 1'b1;
    end

    if (!rst_n) grant_v = 1'b0;

    if (grant_v) begin
      owner_d = grant_id;
      if (grant_id == owner)
        bcnt_d = (bcnt < CW'(BURST_MAX)) ? bcnt + CW'(1) : bcnt;
      else
        bcnt_d = CW'(1);
    end else begin
      bcnt_d = '0;
    end

    gnt0 = grant_v & ~grant_id;
    gnt1 = grant_v & grant_id;
    if (grant_v && grant_id) rom_addr = AW'(addr1);
  end

  // Stage 1: remember which grant was issued while the ROM performs its read
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_id <= 1'b0;
    end else begin
      s1_v  <= grant_v;
      s1_id <= grant_id;
    end
  end

  // Stage 2: response; id and data hold between valid strobes
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rid    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= s1_v;
      if (s1_v) begin
        rid   <= s1_id;
        rdata <= DW'(rom_rdata);
      end
    end
  end

`ifdef BM_CF_ARB_STATS_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && (gcnt0 != 16'hFFFF)) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && (gcnt1 != 16'hFFFF)) gcnt1 <= gcnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bm_cf_rom_arb.sv
// Bench for bm_cf_rom_arb: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration rules and response pipeline.
module tb_bm_cf_rom_arb;

  localparam int BM = 4;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1;
  logic [6:0]  rom_addr;
  logic [32:0] rom_rdata = '0;
  logic        rvalid, rid;
  logic [32:0] rdata;
`ifdef BM_CF_ARB_STATS_EN
  logic [15:0] gcnt0, gcnt1;
`endif

  bm_cf_rom_arb #(.BURST_MAX(BM)) dut (
    .clock(clock), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rvalid(rvalid), .rid(rid), .rdata(rdata)
`ifdef BM_CF_ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data for an address appears one cycle later
  logic [32:0] rom_mem [128];
  always @(posedge clock) rom_rdata <= rom_mem[rom_addr];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_owner, m_cnt;
  bit          p1_v;
  int          p1_id;
  logic [6:0]  p1_addr;
  logic        m_rv, m_rid;
  logic [32:0] m_rdata;
  int          gc0, gc1;
  logic        obs_g1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; p1_v = 0; p1_id = 0; p1_addr = '0;
    m_rv = 0; m_rid = 0; m_rdata = '0; gc0 = 0; gc1 = 0;
  endtask

  // One clock cycle: drive, check combinational and registered outputs, advance model
  task automatic step(input bit r0, input bit r1, input logic [6:0] a0, input logic [6:0] a1);
    bit gv;
    int g;
    logic [6:0] ea;
    @(negedge clock);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    #1;
    gv = 0; g = 0;
    if (r0 && r1) begin
      gv = 1; g = (m_cnt < BM) ? m_owner : 1 - m_owner;
    end else if (r0) begin
      gv = 1; g = 0;
    end else if (r1) begin
      gv = 1; g = 1;
    end
    ea = (gv && g == 1) ? a1 : a0;
    obs_g1 = gnt1;
    chk("gnt0", 64'(gnt0), 64'(gv && g == 0));
    chk("gnt1", 64'(gnt1), 64'(gv && g == 1));
    chk("rom_addr", 64'(rom_addr), 64'(ea));
    chk("rvalid", 64'(rvalid), 64'(m_rv));
    chk("rid", 64'(rid), 64'(m_rid));
    chk("rdata", 64'(rdata), 64'(m_rdata));
`ifdef BM_CF_ARB_STATS_EN
    chk("gcnt0", 64'(gcnt0), 64'(gc0));
    chk("gcnt1", 64'(gcnt1), 64'(gc1));
`endif
    m_rv = p1_v;
    if (p1_v) begin
      m_rid = p1_id[0];
      m_rdata = rom_mem[p1_addr];
    end
    p1_v = gv; p1_id = g; p1_addr = ea;
    if (gv) begin
      m_cnt = (g == m_owner) ? ((m_cnt < BM) ? m_cnt + 1 : m_cnt) : 1;
      m_owner = g;
      if (g == 0 && gc0 < 65535) gc0++;
      if (g == 1 && gc1 < 65535) gc1++;
    end else begin
      m_cnt = 0;
    end
    @(posedge clock);
    #1;
  endtask

  // Reset pulse of about one cycle with requests held high: grants must stay low
  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rst_gnt0", 64'(gnt0), 64'(0));
    chk("rst_gnt1", 64'(gnt1), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rid", 64'(rid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    @(negedge clock);
    chk("rst_rvalid_hold", 64'(rvalid), 64'(0));
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int pat[9];
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 128; i++) rom_mem[i] = 33'({$urandom, $urandom});
    rom_mem[0]  = {20'd524290, 13'd4080};
    rom_mem[64] = {20'd741458, 13'd5770};
    model_reset();

    do_reset();

    // Single request from requester 0, address 0
    step(1, 0, 7'd0, 7'd5);
    step(0, 0, 7'd3, 7'd3);
    chk("r0_rvalid", 64'(rvalid), 64'(1));
    chk("r0_rid", 64'(rid), 64'(0));
    chk("r0_rdata", 64'(rdata), 64'({20'd524290, 13'd4080}));
    step(0, 0, 7'd3, 7'd3);

    // Single request from requester 1, address 64
    step(0, 1, 7'd9, 7'd64);
    step(0, 0, 7'd1, 7'd1);
    chk("r1_rvalid", 64'(rvalid), 64'(1));
    chk("r1_rid", 64'(rid), 64'(1));
    chk("r1_rdata", 64'(rdata), 64'({20'd741458, 13'd5770}));
    step(0, 0, 7'd1, 7'd1);
    step(0, 0, 7'd1, 7'd1);

    // Continuous contention from reset: bursts of BURST_MAX
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 7'(i), 7'(64 + i));
      chk("burst_pattern", 64'(obs_g1), 64'(pat[i]));
    end
    step(0, 0, 7'd0, 7'd0);
    step(0, 0, 7'd0, 7'd0);

    // Requester 0 drops after two grants; requester 1 takes over, count restarts
    step(1, 1, 7'd10, 7'd20);
    step(1, 1, 7'd11, 7'd21);
    step(0, 1, 7'd12, 7'd22);
    chk("drop_handover", 64'(obs_g1), 64'(1));
    for (int i = 0; i < 5; i++) step(1, 1, 7'(30 + i), 7'(40 + i));
    step(0, 0, 7'd0, 7'd0);
    step(0, 0, 7'd0, 7'd0);

    // Reset one cycle after a grant: the in-flight response is discarded
    step(0, 1, 7'd2, 7'd7);
    do_reset();
    step(0, 0, 7'd0, 7'd0);
    chk("inflight_dropped", 64'(rvalid), 64'(0));
    step(0, 0, 7'd0, 7'd0);
    step(1, 1, 7'd4, 7'd8);
    chk("post_reset_prio", 64'(obs_g1), 64'(0));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      step(r < 6, (r >= 3) && (r < 9), 7'($urandom), 7'($urandom));
    end
    step(0, 0, 7'd0, 7'd0);
    step(0, 0, 7'd0, 7'd0);

`ifdef BM_CF_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 70000; i++) step(1, 0, 7'($urandom), 7'd0);
    step(0, 0, 7'd0, 7'd0);
    chk("gcnt0_sat", 64'(gcnt0), 64'(16'hFFFF));
    chk("gcnt1_zero", 64'(gcnt1), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
